// File: rtl/mem_arbiter_pkg.sv
// Shared memory-port types for the core plus the register image of the
// instruction/data memory arbiter.
//   mem_in_type  (72b): request  {valid, instr, mode[1:0], addr, wdata, wstrb}
//   mem_out_type (34b): response {ready, error, rdata}
package mem_arbiter_pkg;

    // Counter width held in the arbiter register image.
    localparam int MEM_ARB_TW = 16;

    typedef struct packed {
        logic        mem_valid;
        logic        mem_instr;
        logic [1:0]  mem_mode;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic [3:0]  mem_wstrb;
    } mem_in_type;

    typedef struct packed {
        logic        mem_ready;
        logic        mem_error;
        logic [31:0] mem_rdata;
    } mem_out_type;

    localparam mem_in_type  init_mem_in  = '0;
    localparam mem_out_type init_mem_out = '0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_type;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_type;

    typedef struct packed {
        arb_state_type          state;
        grant_type              last_grant;
        logic                   pend_i_valid;
        mem_in_type             pend_i;
        logic                   pend_d_valid;
        mem_in_type             pend_d;
        logic [MEM_ARB_TW-1:0]  counter;
    } mem_arbiter_reg_type;

    localparam mem_arbiter_reg_type init_mem_arbiter_reg = '{
        state:        IDLE,
        last_grant:   GRANT_I,
        pend_i_valid: 1'b0,
        pend_i:       init_mem_in,
        pend_d_valid: 1'b0,
        pend_d:       init_mem_in,
        counter:      '0
    };

endpackage

// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction fetch and the load/store unit.
// One outstanding request per requester, round-robin on contention, an
// optional bus timeout that turns a hung access into an error response.
// Ports:
//   clock, reset        : clock, synchronous active-high reset
//   imem_in / imem_out  : fetch request / response
//   dmem_in / dmem_out  : load/store request / response
//   mem_in  / mem_out   : request to / response from memory
// TW must cover TIMEOUT (TIMEOUT < 2**TW); TIMEOUT = 0 disables the timeout.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 0,
    parameter int TW      = MEM_ARB_TW
) (
    input  logic        clock,
    input  logic        reset,
    input  mem_in_type  imem_in,
    output mem_out_type imem_out,
    input  mem_in_type  dmem_in,
    output mem_out_type dmem_out,
    output mem_in_type  mem_in,
    input  mem_out_type mem_out
);

    localparam logic [TW-1:0] TMO = TW'(TIMEOUT);
    localparam mem_out_type   TMO_RSP = '{mem_ready: 1'b1, mem_error: 1'b1, mem_rdata: 32'h0};

    mem_arbiter_reg_type r, rin;

    logic                  live_i, live_d, cand_i, cand_d;
    logic                  fwd_i, fwd_d, tmo_hit;
    mem_in_type            req_i, req_d;
    logic [MEM_ARB_TW-1:0] cnt_inc;

    always_comb begin
        rin      = r;
        mem_in   = init_mem_in;
        imem_out = init_mem_out;
        dmem_out = init_mem_out;
        fwd_i    = 1'b0;
        fwd_d    = 1'b0;

        // A pulse from a requester that already has a request pending or in
        // flight is a protocol violation and is dropped here.
        live_i = imem_in.mem_valid && !r.pend_i_valid && (r.state != BUSY_I);
        live_d = dmem_in.mem_valid && !r.pend_d_valid && (r.state != BUSY_D);
        cand_i = r.pend_i_valid || live_i;
        cand_d = r.pend_d_valid || live_d;
        req_i  = r.pend_i_valid ? r.pend_i : imem_in;
        req_d  = r.pend_d_valid ? r.pend_d : dmem_in;

        // Fires on the TIMEOUT-th busy cycle (counter is 0 in the first one).
        cnt_inc = r.counter + 1'b1;
        tmo_hit = (TIMEOUT > 0) && (TW'(cnt_inc) == TMO);

        unique case (r.state)
            IDLE: begin
                if (cand_i || cand_d) begin
                    // On contention the requester not granted last wins.
                    fwd_d       = cand_d && (!cand_i || r.last_grant == GRANT_I);
                    fwd_i       = !fwd_d;
                    rin.counter = '0;
                    if (fwd_d) begin
                        mem_in           = req_d;
                        rin.state        = BUSY_D;
                        rin.pend_d_valid = 1'b0;
                    end else begin
                        mem_in           = req_i;
                        rin.state        = BUSY_I;
                        rin.pend_i_valid = 1'b0;
                    end
                    mem_in.mem_valid = 1'b1;
                end
            end
            BUSY_I: begin
                if (mem_out.mem_ready) begin
                    imem_out       = mem_out;
                    rin.state      = IDLE;
                    rin.last_grant = GRANT_I;
                end else if (tmo_hit) begin
                    imem_out       = TMO_RSP;
                    rin.state      = IDLE;
                    rin.last_grant = GRANT_I;
                end else begin
                    rin.counter = cnt_inc;
                end
            end
            BUSY_D: begin
                if (mem_out.mem_ready) begin
                    dmem_out       = mem_out;
                    rin.state      = IDLE;
                    rin.last_grant = GRANT_D;
                end else if (tmo_hit) begin
                    dmem_out       = TMO_RSP;
                    rin.state      = IDLE;
                    rin.last_grant = GRANT_D;
                end else begin
                    rin.counter = cnt_inc;
                end
            end
            default: rin.state = IDLE;
        endcase

        // Live requests not forwarded this cycle wait in their slot.
        if (live_i && !fwd_i) begin
            rin.pend_i_valid = 1'b1;
            rin.pend_i       = imem_in;
        end
        if (live_d && !fwd_d) begin
            rin.pend_d_valid = 1'b1;
            rin.pend_d       = dmem_in;
        end

        if (reset) begin
            mem_in   = init_mem_in;
            imem_out = init_mem_out;
            dmem_out = init_mem_out;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) r <= init_mem_arbiter_reg;
        else       r <= rin;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int TMO = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    mem_in_type  imem_in, dmem_in, mem_in;
    mem_out_type imem_out, dmem_out, mem_out;

    mem_arbiter #(.TIMEOUT(TMO), .TW(16)) dut (
        .clock(clock), .reset(reset),
        .imem_in(imem_in), .imem_out(imem_out),
        .dmem_in(dmem_in), .dmem_out(dmem_out),
        .mem_in(mem_in), .mem_out(mem_out)
    );

    always #5 clock = ~clock;

    int nchk = 0;
    int nerr = 0;

    task automatic chk(input string tag, input logic [71:0] act, input logic [71:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h want %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Reference model: which requester owns the port (-1 none), waiting
    // requests per requester (0 = fetch, 1 = data), who was granted last,
    // and how many busy cycles the current access has lasted.
    int          own = -1;
    bit          pv[2];
    mem_in_type  pq[2];
    int          last = 0;
    int          bcnt = 0;
    bit          outst[2];
    int          mem_due = -1;
    mem_in_type  em;
    mem_out_type eo[2];
    mem_in_type  snap_mi;
    mem_out_type snap_io, snap_do;

    function automatic mem_in_type mk(bit instr, logic [31:0] addr, logic [31:0] wdata, logic [3:0] wstrb);
        mem_in_type m;
        m = '0;
        m.mem_valid = 1'b1;
        m.mem_instr = instr;
        m.mem_mode  = instr ? 2'd0 : 2'd1;
        m.mem_addr  = addr;
        m.mem_wdata = wdata;
        m.mem_wstrb = wstrb;
        return m;
    endfunction

    function automatic mem_out_type rsp(logic [31:0] d);
        mem_out_type o;
        o = '0;
        o.mem_ready = 1'b1;
        o.mem_rdata = d;
        return o;
    endfunction

    // One clock: drive, then on the falling edge predict and compare.
    task automatic step(input mem_in_type ri, input mem_in_type rd, input mem_out_type mo, input logic rst);
        mem_in_type lv[2];
        mem_in_type rq[2];
        bit         cand[2];
        int         w;
        imem_in = ri;
        dmem_in = rd;
        mem_out = mo;
        reset   = rst;
        @(negedge clock);
        lv[0] = ri;
        lv[1] = rd;
        em    = '0;
        eo[0] = '0;
        eo[1] = '0;
        if (rst) begin
            own = -1; pv[0] = 0; pv[1] = 0; last = 0; bcnt = 0;
            outst[0] = 0; outst[1] = 0; mem_due = -1;
        end else begin
            for (int k = 0; k < 2; k++) begin
                assert (!(lv[k].mem_valid && (pv[k] || own == k)))
                    else $error("requester %0d pulsed with a request outstanding", k);
                cand[k] = pv[k] || lv[k].mem_valid;
                rq[k]   = pv[k] ? pq[k] : lv[k];
            end
            if (own < 0) begin
                if (cand[0] && cand[1]) w = 1 - last;
                else if (cand[0])       w = 0;
                else if (cand[1])       w = 1;
                else                    w = -1;
                if (w >= 0) begin
                    em = rq[w];
                    em.mem_valid = 1'b1;
                    own = w; bcnt = 0; pv[w] = 0;
                end
                for (int k = 0; k < 2; k++)
                    if (k != w && lv[k].mem_valid) begin pv[k] = 1; pq[k] = lv[k]; end
            end else begin
                for (int k = 0; k < 2; k++)
                    if (lv[k].mem_valid) begin pv[k] = 1; pq[k] = lv[k]; end
                bcnt++;
                if (mo.mem_ready) begin
                    eo[own] = mo; last = own; own = -1;
                end else if (bcnt == TMO) begin
                    eo[own] = '{mem_ready: 1'b1, mem_error: 1'b1, mem_rdata: 32'h0};
                    last = own; own = -1;
                end
            end
        end
        snap_mi = mem_in;
        snap_io = imem_out;
        snap_do = dmem_out;
        chk("mem_in", 72'(mem_in), 72'(em));
        chk("imem_out", 72'(imem_out), 72'(eo[0]));
        chk("dmem_out", 72'(dmem_out), 72'(eo[1]));
        if (eo[0].mem_ready) outst[0] = 0;
        if (eo[1].mem_ready) outst[1] = 0;
        @(posedge clock);
        #1;
    endtask

    mem_in_type  z, ri, rd, rd2;
    mem_out_type mz, mo;

    initial begin
        z = '0; mz = '0;
        #1;
        // Reset held while both requesters pulse.
        for (int c = 0; c < 3; c++) begin
            step(mk(1, 32'h40, 0, 0), mk(0, 32'h44, 1, 4'hF), mz, 1);
            chk("reset_mem_in", 72'(snap_mi), 72'h0);
        end
        step(z, z, mz, 0);
        chk("no_stale_grant", 72'(snap_mi.mem_valid), 72'h0);

        // Lone fetch, answered 3 cycles later.
        step(mk(1, 32'h8000_0000, 0, 0), z, mz, 0);
        chk("fetch_addr", 72'(snap_mi.mem_addr), 72'h8000_0000);
        chk("fetch_instr", 72'(snap_mi.mem_instr), 72'h1);
        step(z, z, mz, 0);
        step(z, z, mz, 0);
        step(z, z, rsp(32'h0000_0013), 0);
        chk("fetch_rsp", 72'(snap_io), 72'(rsp(32'h0000_0013)));
        chk("fetch_dmem_quiet", 72'(snap_do), 72'h0);

        // Contention after reset: data first, instruction after one bubble.
        step(z, z, mz, 1);
        ri = mk(1, 32'h100, 0, 0);
        rd = mk(0, 32'h2000, 32'hDEAD_BEEF, 4'hF);
        step(ri, rd, mz, 0);
        chk("pair1_first", 72'(snap_mi.mem_addr), 72'h2000);
        chk("pair1_wdata", 72'(snap_mi.mem_wdata), 72'hDEAD_BEEF);
        step(z, z, mz, 0);
        step(z, z, rsp(32'h1), 0);
        step(z, z, mz, 0);
        chk("pair1_second", 72'(snap_mi.mem_addr), 72'h100);
        step(z, z, rsp(32'h2), 0);
        // Instruction was granted last, so data wins this pair.
        step(ri, rd, mz, 0);
        chk("pair2_first", 72'(snap_mi.mem_addr), 72'h2000);
        step(z, z, rsp(32'h3), 0);
        step(z, z, mz, 0);
        step(z, z, rsp(32'h4), 0);
        // Lone data access makes data the last grant; the next pair goes to fetch.
        step(z, rd, mz, 0);
        step(z, z, rsp(32'h5), 0);
        step(ri, rd, mz, 0);
        chk("pair3_first", 72'(snap_mi.mem_addr), 72'h100);
        step(z, z, rsp(32'h6), 0);
        step(z, z, mz, 0);
        step(z, z, rsp(32'h7), 0);

        // Data request two cycles into a fetch waits in its slot.
        rd2 = mk(0, 32'h3000, 32'h1234_5678, 4'h3);
        step(mk(1, 32'h200, 0, 0), z, mz, 0);
        step(z, z, mz, 0);
        step(z, rd2, mz, 0);
        step(z, z, mz, 0);
        step(z, z, rsp(32'h8), 0);
        step(z, z, mz, 0);
        chk("slot_wdata", 72'(snap_mi.mem_wdata), 72'h1234_5678);
        chk("slot_wstrb", 72'(snap_mi.mem_wstrb), 72'h3);
        step(z, z, rsp(32'h9), 0);

        // Hung access times out on the 8th busy cycle; late ready is dropped.
        step(mk(1, 32'h300, 0, 0), z, mz, 0);
        for (int c = 1; c <= 11; c++) begin
            step(z, z, mz, 0);
            if (c == TMO) begin
                chk("tmo_ready", 72'(snap_io.mem_ready), 72'h1);
                chk("tmo_error", 72'(snap_io.mem_error), 72'h1);
            end
        end
        step(z, z, rsp(32'hBAD), 0);
        chk("late_ready_dropped", 72'(snap_io), 72'h0);

        // Reset during a data access with a fetch waiting.
        step(z, rd, mz, 0);
        step(ri, z, mz, 0);
        step(z, z, mz, 1);
        step(z, z, rsp(32'hA), 0);
        chk("discard_i", 72'(snap_io.mem_ready), 72'h0);
        chk("discard_d", 72'(snap_do.mem_ready), 72'h0);
        step(mk(1, 32'h400, 0, 0), z, mz, 0);
        chk("fresh_grant", 72'(snap_mi.mem_valid), 72'h1);
        step(z, z, rsp(32'hB), 0);
        step(z, z, mz, 1);

        // Randomized traffic with a random-latency memory.
        for (int c = 0; c < 4000; c++) begin
            ri = '0; rd = '0; mo = '0;
            if (!outst[0] && $urandom_range(0, 2) == 0) begin
                ri = mk(1, $urandom, 0, 0);
                ri.mem_mode = 2'($urandom);
                outst[0] = 1;
            end
            if (!outst[1] && $urandom_range(0, 2) == 0) begin
                rd = mk(0, $urandom, $urandom, 4'($urandom));
                rd.mem_mode = 2'($urandom);
                outst[1] = 1;
            end
            if (mem_due == 0) begin
                mo = rsp($urandom);
                mo.mem_error = ($urandom_range(0, 7) == 0);
                mem_due = -1;
            end else if (mem_due > 0) begin
                mem_due--;
            end else if ($urandom_range(0, 15) == 0) begin
                mo = rsp($urandom);
            end
            step(ri, rd, mo, ($urandom_range(0, 299) == 0));
            if (em.mem_valid)
                mem_due = ($urandom_range(0, 9) == 0) ? 12 : int'($urandom_range(0, 4));
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single core memory port (mem_in_type / mem_out_type) between instruction fetch and the data load/store unit.
- Sits between the fetch/execute stages and the external memory/bus bridge.
- Holds at most one outstanding request per requester.
- Uses round-robin selection when both requesters contend.
- Has an optional bus-timeout that converts a hung access into an error response.

Parameters:
- TIMEOUT, 0, cycles to wait for mem_ready before returning mem_error to the owner; 0 disables the timeout.
- TW, 16, width of the timeout counter; must satisfy TIMEOUT < 2**TW.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_in  in  mem_in_type (72)  instruction request from fetch.
- imem_out  out  mem_out_type (34)  response to fetch.
- dmem_in  in  mem_in_type (72)  data request from execute.
- dmem_out  out  mem_out_type (34)  response to execute.
- mem_in  out  mem_in_type (72)  request to memory.
- mem_out  in  mem_out_type (34)  response from memory.

Behaviour:
- Request protocol:
  - A requester pulses mem_valid for exactly one cycle; addr, wdata, wstrb, instr and mode are valid in that cycle.
  - It must not pulse again until it has seen its own mem_ready.
  - A second pulse while that requester's request is pending or in flight is a protocol violation: the bench asserts, the RTL ignores it.
- Memory protocol: mem_in.mem_valid is a one-cycle pulse; memory answers with a one-cycle mem_ready (mem_error qualified by ready) any number of cycles later.
- Pending slots:
  - One per requester: pend_i and pend_d, each a valid flag plus the captured mem_in_type.
  - A request not forwarded in its arrival cycle is captured into its slot at the clock edge.
- State machine: IDLE, BUSY_I, BUSY_D.
- IDLE:
  - Candidates are the pending slots plus live valid requests.
  - Live and pending for the same requester cannot coexist.
  - One candidate: forward it combinationally in the same cycle (zero added latency) and go to BUSY_x.
  - Two candidates: the winner is the requester not granted last (last_grant register, reset value = instruction, so data wins first). Forward the winner and capture the loser into its slot.
  - A forwarded pending entry clears its slot on the same edge.
- BUSY_x:
  - mem_in.mem_valid = 0; new requests are captured into slots.
  - mem_out is routed to the owner (x_out = mem_out) in the cycle mem_ready = 1; the non-owner output is all-zero.
  - On mem_ready, go to IDLE and update last_grant = x. The next grant is issued no earlier than the following cycle, so there is one bubble between back-to-back accesses.
- Timeout (TIMEOUT > 0):
  - The counter clears on every grant and increments each BUSY cycle.
  - When it equals TIMEOUT without mem_ready, drive the owner's output with ready=1, error=1, rdata=0 for one cycle and go to IDLE.
  - A late mem_ready arriving in IDLE is dropped.
- mem_out asserted in IDLE (no owner): dropped; both outputs stay zero.
- Reset values: state IDLE; both slots invalid; last_grant = instruction; counter 0. All outputs are zero in the reset cycle regardless of inputs.
- Reset mid-access: the in-flight transaction and pending slots are discarded, and no response is delivered for them.
- Outputs in IDLE with no candidate: mem_in = init_mem_in; imem_out = dmem_out = init_mem_out.
- mem_mode and mem_instr are passed through unchanged from the granted request.

Decomposition:
- Add to the shared wires package:
  - arb_state_type, a 2-bit enum with values IDLE / BUSY_I / BUSY_D.
  - mem_arbiter_reg_type, a packed struct holding state, last_grant, pend_i_valid, pend_i, pend_d_valid, pend_d and counter [TW-1:0].
  - init_mem_arbiter_reg parameter, built from init_mem_in.
- Implementation style: single module with a combinational next-state block and one registered update. No sub-module is needed.

Test Plan:
- Reset: hold reset=1 for 3 cycles while both requesters pulse valid → all outputs 0. After release, no stale grant appears.
- Lone instruction fetch: imem_in valid at addr 0x80000000 while IDLE → mem_in same cycle with addr 0x80000000 and mem_instr=1. Memory returns rdata 0x00000013 after 3 cycles → imem_out ready=1 with that data in that cycle; dmem_out stays 0.
- Simultaneous requests after reset: imem 0x100 and dmem 0x2000 (wstrb 0xF, wdata 0xDEADBEEF) → data issued first. Instruction is issued the cycle after data's ready (one bubble). A third pair then grants instruction first (round-robin).
- Request during BUSY_I: dmem pulses 2 cycles into a fetch → captured in the slot and issued exactly one cycle after the imem ready. Its wdata/wstrb match the captured values.
- Timeout with TIMEOUT=8: memory never answers → owner gets ready=1, error=1 on the 8th BUSY cycle, then IDLE. A late mem_ready at cycle 12 produces no output.
- Reset mid-access: assert reset during BUSY_D with pend_i set → after reset, neither output sees ready for the discarded requests, and a fresh imem request is granted immediately.
